// File: rtl/rect_fill_engine_if.sv
// Pixel-write request/response bundle between a fill requester and rect_fill_engine.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy/done and the adapter consumes one pixel per cycle.
// Signals: start/abort/x0/y0/w/h/fg_colour/bg_colour/mode go requester -> engine;
//          x/y/colour/plot/busy/done go engine -> requester/adapter.
interface rect_fill_engine_if #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                abort;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic [1:0]          mode;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    // Requester side: issues fills, observes pixels and status.
    modport master (
        output start, abort, x0, y0, w, h, fg_colour, bg_colour, mode,
        input  x, y, colour, plot, busy, done
    );

    // Engine side.
    modport slave (
        input  start, abort, x0, y0, w, h, fg_colour, bg_colour, mode,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Raster-fill engine: walks a screen-clipped rectangle one pixel per cycle (solid/stripes/outline).
// Latency: first pixel the cycle after start is sampled; done pulses the cycle after the last pixel.
// Backpressure: none; start is ignored unless idle, abort cancels a fill without a done pulse.
// Ports: clock_i (rising edge), resetn_i (async active-low), bus (slave modport of rect_fill_engine_if).
module rect_fill_engine #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int STRIPE_H = 4
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    rect_fill_engine_if.slave   bus
);
    localparam int BAND_W = (STRIPE_H > 1) ? $clog2(STRIPE_H) : 1;
    localparam logic [X_W:0]    SW_EXT   = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]    SH_EXT   = (Y_W+1)'(SCREEN_H);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(STRIPE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    // Extents are kept one bit wider so ew-1 / eh-1 compares never wrap.
    logic [X_W:0]        ew_q, ew_d;
    logic [Y_W:0]        eh_q, eh_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;
    logic [BAND_W-1:0]   band_q, band_d;   // row within the current stripe band
    logic                odd_q, odd_d;     // current band uses bg colour
    logic [COLOUR_W-1:0] fg_q, fg_d;
    logic [COLOUR_W-1:0] bg_q, bg_d;
    logic                stripe_q, stripe_d;
    logic                outline_q, outline_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Clipped extents of the incoming request (only meaningful in IDLE).
    logic [X_W:0] x0_ext, x_room, w_ext, ew_c;
    logic [Y_W:0] y0_ext, y_room, h_ext, eh_c;

    assign x0_ext = {1'b0, bus.x0};
    assign y0_ext = {1'b0, bus.y0};
    assign w_ext  = {1'b0, bus.w};
    assign h_ext  = {1'b0, bus.h};
    assign x_room = SW_EXT - x0_ext;
    assign y_room = SH_EXT - y0_ext;

    always_comb begin
        ew_c = '0;
        if (x0_ext < SW_EXT) begin
            ew_c = (w_ext < x_room) ? w_ext : x_room;
        end
        eh_c = '0;
        if (y0_ext < SH_EXT) begin
            eh_c = (h_ext < y_room) ? h_ext : y_room;
        end
    end

    logic last_col, last_row, edge_px;

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        ew_d      = ew_q;
        eh_d      = eh_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        band_d    = band_q;
        odd_d     = odd_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        stripe_d  = stripe_q;
        outline_d = outline_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        last_col  = ({1'b0, cx_q} == ew_q - 1'b1);
        last_row  = ({1'b0, cy_q} == eh_q - 1'b1);
        edge_px   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x0_d      = bus.x0;
                    y0_d      = bus.y0;
                    ew_d      = ew_c;
                    eh_d      = eh_c;
                    fg_d      = bus.fg_colour;
                    bg_d      = bus.bg_colour;
                    stripe_d  = (bus.mode == 2'b01);
                    outline_d = (bus.mode == 2'b10);
                    cx_d      = '0;
                    cy_d      = '0;
                    band_d    = '0;
                    odd_d     = 1'b0;
                    if (ew_c == '0 || eh_c == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Pixel (0,0) is a corner and in an even band: always plotted in fg.
                        state_d  = S_FILL;
                        busy_d   = 1'b1;
                        plot_d   = 1'b1;
                        x_d      = bus.x0;
                        y_d      = bus.y0;
                        colour_d = bus.fg_colour;
                    end
                end
            end
            S_FILL: begin
                // cx_q/cy_q name the pixel currently on the outputs.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (last_col && last_row) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (last_col) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                        if (band_q == BAND_LAST) begin
                            band_d = '0;
                            odd_d  = ~odd_q;
                        end else begin
                            band_d = band_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    edge_px  = (cx_d == '0) || ({1'b0, cx_d} == ew_q - 1'b1) ||
                               (cy_d == '0) || ({1'b0, cy_d} == eh_q - 1'b1);
                    plot_d   = outline_q ? edge_px : 1'b1;
                    colour_d = (stripe_q && odd_d) ? bg_q : fg_q;
                    x_d      = x0_q + cx_d;
                    y_d      = y0_q + cy_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            ew_q      <= '0;
            eh_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            band_q    <= '0;
            odd_q     <= 1'b0;
            fg_q      <= '0;
            bg_q      <= '0;
            stripe_q  <= 1'b0;
            outline_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            ew_q      <= ew_d;
            eh_q      <= eh_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            band_q    <= band_d;
            odd_q     <= odd_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            stripe_q  <= stripe_d;
            outline_q <= outline_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed vector table, random fills against a per-pixel model,
// and hand sequences for abort, ignored restart and asynchronous reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_rect_fill_engine;
    localparam int SW  = 320;
    localparam int SH  = 240;
    localparam int SPH = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    rect_fill_engine_if bus ();

    rect_fill_engine dut (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues one fill and checks every cycle against the model until one idle cycle after done.
    // poke: re-asserts start with other parameters during the fill (must be ignored).
    task automatic run_fill(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                            input logic [7:0] h, input logic [2:0] fg, input logic [2:0] bg,
                            input logic [1:0] md, input bit poke,
                            output int nplots, output int dcyc);
        int ew, eh, n, idx, r, c;
        bit ep;
        logic [2:0] ecol;
        ew = 0;
        for (int i = 0; i < int'(w); i++) if (int'(x0) + i < SW) ew++;
        eh = 0;
        for (int i = 0; i < int'(h); i++) if (int'(y0) + i < SH) eh++;
        n = ew * eh;
        nplots = 0;
        dcyc = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = x0; bus.y0 = y0; bus.w = w; bus.h = h;
        bus.fg_colour = fg; bus.bg_colour = bg; bus.mode = md;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs: the fill must use the latched values.
                bus.start = 1'b0;
                bus.x0 = 9'($urandom); bus.y0 = 8'($urandom);
                bus.w = 9'($urandom); bus.h = 8'($urandom);
                bus.fg_colour = 3'($urandom); bus.bg_colour = 3'($urandom);
                bus.mode = 2'($urandom);
            end
            if (bus.plot) nplots++;
            if (bus.done && dcyc < 0) dcyc = k;
            if (k <= n) begin
                idx  = k - 1;
                r    = idx / ew;
                c    = idx % ew;
                ep   = (md == 2'b10) ? (c == 0 || c == ew - 1 || r == 0 || r == eh - 1) : 1'b1;
                ecol = (md == 2'b01 && ((r / SPH) % 2 == 1)) ? bg : fg;
                if (ep)
                    check("pixel", {9'd0, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour},
                          {9'd0, 3'b110, 9'(int'(x0) + c), 8'(int'(y0) + r), ecol});
                else
                    check("skip", {29'd0, bus.plot, bus.busy, bus.done}, {29'd0, 3'b010});
            end else if (k == n + 1) begin
                check("done", {29'd0, bus.plot, bus.busy, bus.done}, {29'd0, 3'b001});
            end else begin
                check("idle", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
            end
            if (poke && k == 2) begin
                bus.start = 1'b1; bus.x0 = 9'd100; bus.w = 9'd50; bus.h = 8'd50;
            end
            if (poke && k == 3) bus.start = 1'b0;
        end
        check("done_cycle", dcyc, n + 1);
    endtask

    typedef struct {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] fg;
        logic [2:0] bg;
        logic [1:0] md;
        bit         poke;
        int         plots;
        int         dcyc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int np, dc;
        bit quiet;
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{9'd0,   8'd0,   9'd320, 8'd240, 3'd7, 3'd0, 2'b00, 1'b0, 76800, 76801};
        vecs[1]  = '{9'd10,  8'd5,   9'd3,   8'd2,   3'd5, 3'd0, 2'b00, 1'b0, 6,     7};
        vecs[2]  = '{9'd300, 8'd230, 9'd50,  8'd50,  3'd6, 3'd1, 2'b00, 1'b0, 200,   201};
        vecs[3]  = '{9'd320, 8'd0,   9'd5,   8'd5,   3'd7, 3'd0, 2'b00, 1'b0, 0,     1};
        vecs[4]  = '{9'd10,  8'd10,  9'd0,   8'd5,   3'd7, 3'd0, 2'b00, 1'b0, 0,     1};
        vecs[5]  = '{9'd0,   8'd0,   9'd3,   8'd10,  3'd1, 3'd2, 2'b01, 1'b0, 30,    31};
        vecs[6]  = '{9'd20,  8'd20,  9'd4,   8'd3,   3'd3, 3'd0, 2'b10, 1'b0, 10,    13};
        vecs[7]  = '{9'd50,  8'd60,  9'd2,   8'd2,   3'd4, 3'd2, 2'b11, 1'b0, 4,     5};
        vecs[8]  = '{9'd319, 8'd239, 9'd5,   8'd5,   3'd2, 3'd0, 2'b00, 1'b0, 1,     2};
        vecs[9]  = '{9'd0,   8'd250, 9'd5,   8'd5,   3'd2, 3'd0, 2'b00, 1'b0, 0,     1};
        vecs[10] = '{9'd0,   8'd0,   9'd4,   8'd4,   3'd6, 3'd0, 2'b00, 1'b1, 16,    17};

        bus.start = 1'b0; bus.abort = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        bus.fg_colour = '0; bus.bg_colour = '0; bus.mode = '0;
        rst_n = 1'b0;
        #12;
        check("reset_out", {9'd0, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_fill(vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].fg, vecs[v].bg,
                     vecs[v].md, vecs[v].poke, np, dc);
            check("vec_plots", np, vecs[v].plots);
            check("vec_done", dc, vecs[v].dcyc);
        end

        // Abort while pixel 5 of a 4x4 fill is on the outputs.
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = 9'd0; bus.y0 = 8'd0; bus.w = 9'd4; bus.h = 8'd4;
        bus.mode = 2'b00; bus.fg_colour = 3'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("abort_pre", {10'd0, bus.plot, bus.busy, bus.x, bus.y},
                  {10'd0, 2'b11, 9'((k - 1) % 4), 8'((k - 1) / 4)});
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_next", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.plot || bus.done || bus.busy) quiet = 1'b0;
        end
        check("abort_quiet", {31'd0, quiet}, 32'd1);

        // Asynchronous reset in the middle of a fill.
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = 9'd5; bus.y0 = 8'd5; bus.w = 9'd10; bus.h = 8'd10;
        bus.fg_colour = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_plot", {31'd0, bus.plot}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {9'd0, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.plot || bus.done || bus.busy) quiet = 1'b0;
        end
        check("reset_quiet", {31'd0, quiet}, 32'd1);

        // Random fills, including off-screen and clipped placements.
        for (int t = 0; t < 20; t++) begin
            run_fill(9'($urandom_range(330, 0)), 8'($urandom_range(250, 0)),
                     9'($urandom_range(15, 0)), 8'($urandom_range(15, 0)),
                     3'($urandom), 3'($urandom), 2'($urandom), 1'b0, np, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
